// File: rtl/bf_pkg.sv
// -----------------------------------------------------------------------------
// bf_pkg
//  Shared definitions for the butterfly result serializer.
//  W          packed complex sample width at the serializer output
//  PART_W     width of one real/imag part after narrowing (W/2)
//  IN_PART_W  width of one real/imag part coming out of the butterfly (W/2+1)
//  bf_state_e output sequencer states
// -----------------------------------------------------------------------------
package bf_pkg;

   localparam int W         = 32;
   localparam int PART_W    = W / 2;
   localparam int IN_PART_W = W / 2 + 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SEND_P0 = 2'd1,
      ST_SEND_P1 = 2'd2
   } bf_state_e;

endpackage

// File: rtl/bf_narrow.sv
// -----------------------------------------------------------------------------
// bf_narrow
//  Combinational narrowing of one signed real/imag part from IN_W to OUT_W bits.
//  SCALE=1: y = (x+1)>>>1 (round half up), then saturate to OUT_W bits.
//  SCALE=0: saturate x directly.
// Ports
//  x    in   IN_W   signed input part
//  y    out  OUT_W  narrowed, saturated part
//  sat  out  1      the value was clamped
// -----------------------------------------------------------------------------
module bf_narrow
   import bf_pkg::*;
#(
   parameter int IN_W  = IN_PART_W,
   parameter int OUT_W = PART_W,
   parameter bit SCALE = 1'b1
) (
   input  logic [IN_W-1:0]  x,
   output logic [OUT_W-1:0] y,
   output logic             sat
);

   // Limits of the OUT_W-bit signed range, expressed in the IN_W+1 bit work width.
   localparam logic signed [IN_W:0] MAX_V = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [IN_W:0] MIN_V = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
   localparam logic signed [IN_W:0] ONE   = 1;

   logic signed [IN_W:0] ext;
   logic signed [IN_W:0] val;

   // NOTE: every signal written here gets a default first, so no path can leave
   // it unassigned and infer a latch.
   always_comb begin
      ext = $signed({x[IN_W-1], x});
      val = ext;
      if (SCALE) begin
         // One extra bit of headroom keeps x+1 from wrapping at the top of range.
         val = (ext + ONE) >>> 1;
      end
      sat = 1'b0;
      y   = val[OUT_W-1:0];
      if (val > MAX_V) begin
         y   = MAX_V[OUT_W-1:0];
         sat = 1'b1;
      end else if (val < MIN_V) begin
         y   = MIN_V[OUT_W-1:0];
         sat = 1'b1;
      end
   end

endmodule

// File: rtl/bf_result_serializer.sv
// -----------------------------------------------------------------------------
// bf_result_serializer
//  Back end of the radix-2 butterfly: narrows each dout_p0/dout_p1 pair, buffers
//  the pairs in a FIFO and streams them out one complex sample per beat with
//  tlast framing. The butterfly cannot stall, so a push into a full FIFO (with no
//  pop in the same cycle) drops the pair and sets the sticky ovf_flag.
// Ports
//  aclk, aresetn     clock, asynchronous active-low reset
//  s_valid           dout_p0/dout_p1 hold a valid pair
//  dout_p0, dout_p1  {imag, real}, each part W/2+1 bits signed
//  s_almost_full     registered: FIFO count >= FIFO_DEPTH-4
//  m_axis_*          AXI-Stream-style master, one W-bit {imag, real} sample per beat
//  ovf_flag          sticky: a pair was dropped
//  sat_flag          sticky: a part saturated during narrowing
// -----------------------------------------------------------------------------
module bf_result_serializer
   import bf_pkg::*;
#(
   parameter int COMPLEX_A_DWIDTH = W,
   parameter int FIFO_DEPTH       = 16,
   parameter int FRAME_LEN        = 64,
   parameter bit SCALE            = 1'b1
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic                        s_valid,
   input  logic [COMPLEX_A_DWIDTH+1:0] dout_p0,
   input  logic [COMPLEX_A_DWIDTH+1:0] dout_p1,
   output logic                        s_almost_full,
   output logic [COMPLEX_A_DWIDTH-1:0] m_axis_tdata,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic                        m_axis_tlast,
   output logic                        ovf_flag,
   output logic                        sat_flag
);

   localparam int PW     = COMPLEX_A_DWIDTH / 2;
   localparam int IPW    = PW + 1;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int FCNT_W = $clog2(FRAME_LEN);
   localparam logic [FCNT_W-1:0] LAST_IDX  = FCNT_W'(FRAME_LEN - 1);
   localparam logic [PTR_W:0]    DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [PTR_W:0]    AF_CNT    = (PTR_W + 1)'(FIFO_DEPTH - 4);

   typedef struct packed {
      logic [COMPLEX_A_DWIDTH-1:0] p1;
      logic [COMPLEX_A_DWIDTH-1:0] p0;
   } entry_t;

   // ---------------------------------------------------------------- narrowing
   logic [IPW-1:0] part_in  [4];
   logic [PW-1:0]  part_out [4];
   logic [3:0]     part_sat;

   assign part_in[0] = dout_p0[IPW-1:0];
   assign part_in[1] = dout_p0[2*IPW-1:IPW];
   assign part_in[2] = dout_p1[IPW-1:0];
   assign part_in[3] = dout_p1[2*IPW-1:IPW];

   for (genvar g = 0; g < 4; g++) begin : g_narrow
      bf_narrow #(
         .IN_W  (IPW),
         .OUT_W (PW),
         .SCALE (SCALE)
      ) u_narrow (
         .x   (part_in[g]),
         .y   (part_out[g]),
         .sat (part_sat[g])
      );
   end

   // ---------------------------------------------------------------- state
   bf_state_e                   state_q, state_d;
   entry_t                      mem_q [FIFO_DEPTH];
   entry_t                      wr_entry;
   logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_nxt;
   logic [PTR_W:0]              count_q, count_d;
   logic [FCNT_W-1:0]           frame_q, frame_d;
   logic [COMPLEX_A_DWIDTH-1:0] tdata_q, tdata_d;
   logic                        tvalid_q, tvalid_d, tlast_q, tlast_d;
   logic                        ovf_q, ovf_d, sat_q, sat_d, afull_q, afull_d;
   logic                        hs, pop, full, push;

   assign hs         = tvalid_q & m_axis_tready;
   assign pop        = hs & (state_q == ST_SEND_P1);
   assign full       = (count_q == DEPTH_CNT);
   // A full FIFO still accepts when the same cycle pops an entry.
   assign push       = s_valid & (~full | pop);
   assign wr_entry   = '{p1: {part_out[3], part_out[2]}, p0: {part_out[1], part_out[0]}};
   assign rd_ptr_nxt = rd_ptr_q + PTR_W'(1);

   always_comb begin : fifo_ctrl
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_nxt : rd_ptr_q;
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      frame_d = frame_q;
      if (hs) begin
         frame_d = (frame_q == LAST_IDX) ? '0 : frame_q + 1'b1;
      end
      ovf_d   = ovf_q | (s_valid & ~push);
      sat_d   = sat_q | (push & (|part_sat));
      afull_d = (count_d >= AF_CNT);
   end

   // ---------------------------------------------------------------- FSM next state
   always_comb begin : fsm_next
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:    if (count_q != '0) state_d = ST_SEND_P0;
         ST_SEND_P0: if (hs) state_d = ST_SEND_P1;
         // Only entries already stored count; a same-cycle push is picked up via IDLE.
         ST_SEND_P1: if (hs) state_d = (count_q > (PTR_W + 1)'(1)) ? ST_SEND_P0 : ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- FSM outputs
   // The registered beat is loaded on the transition into the state that shows it,
   // so tdata/tvalid change only on a handshake or when leaving IDLE.
   always_comb begin : fsm_out
      tvalid_d = tvalid_q;
      tdata_d  = tdata_q;
      unique case (state_q)
         ST_IDLE: begin
            if (state_d == ST_SEND_P0) begin
               tvalid_d = 1'b1;
               tdata_d  = mem_q[rd_ptr_q].p0;
            end
         end
         ST_SEND_P0: begin
            if (hs) tdata_d = mem_q[rd_ptr_q].p1;
         end
         ST_SEND_P1: begin
            if (hs) begin
               if (state_d == ST_SEND_P0) begin
                  tdata_d = mem_q[rd_ptr_nxt].p0;
               end else begin
                  tvalid_d = 1'b0;
                  tdata_d  = '0;
               end
            end
         end
         default: begin
            tvalid_d = 1'b0;
            tdata_d  = '0;
         end
      endcase
      tlast_d = tvalid_d & (frame_d == LAST_IDX);
   end

   // ---------------------------------------------------------------- registers
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the values from before the edge, independent of statement order.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q  <= ST_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         frame_q  <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         ovf_q    <= 1'b0;
         sat_q    <= 1'b0;
         afull_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         frame_q  <= frame_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         ovf_q    <= ovf_d;
         sat_q    <= sat_d;
         afull_q  <= afull_d;
      end
   end

   // NOTE: the storage array has no reset; the pointers and count define which
   // entries are live, so clearing it would only add reset fan-out.
   always_ff @(posedge aclk) begin
      if (push) mem_q[wr_ptr_q] <= wr_entry;
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign s_almost_full = afull_q;
   assign ovf_flag      = ovf_q;
   assign sat_flag      = sat_q;

endmodule
